// File: rtl/sorter_ctrl.sv
// sorter_ctrl: collects a QPSK/QAM16 sample frame, feeds it to an
// external sorter in groups of four, and returns the registered result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode_in[1:0]        00 QPSK (4 samples), 01 QAM16 (16), 1x reserved
//   s_valid/s_ready     sample handshake, s_data[WIDTH-1:0]
//   srt_start, srt_M    start pulse and latched mode to the sorter
//   srt_d1..srt_d4      one group of four samples per FEED cycle
//   srt_done, srt_y     sorter completion and result
//   m_valid/m_ready     result handshake, m_data registered result
//   busy, err           not-idle flag, one-cycle error pulse
module sorter_ctrl #(
  parameter int WIDTH       = 8,
  parameter int NUM_OUTPUTS = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode_in,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_data,
  output logic                         srt_start,
  output logic [1:0]                   srt_M,
  output logic [WIDTH-1:0]             srt_d1,
  output logic [WIDTH-1:0]             srt_d2,
  output logic [WIDTH-1:0]             srt_d3,
  output logic [WIDTH-1:0]             srt_d4,
  input  logic                         srt_done,
  input  logic [NUM_OUTPUTS*WIDTH-1:0] srt_y,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_OUTPUTS*WIDTH-1:0] m_data,
  output logic                         busy,
  output logic                         err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    START,
    FEED,
    WAIT,
    OUT
  } state_t;

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] sbuf [16];
  logic [4:0]       idx;
  logic [TW-1:0]    tcnt;
  logic [1:0]       mode_q;

  logic       xfer;
  logic       qam;
  logic       col_last;
  logic       feed_last;
  logic       t_exp;
  logic       err_set;
  logic [3:0] gbase;

  assign xfer = s_valid & s_ready;
  assign qam  = (mode_q == 2'b01);

  // The index counts samples while collecting and then groups
  // while feeding; both phases start it from zero.
  assign col_last  = qam ? (idx == 5'd15) : (idx == 5'd3);
  assign feed_last = qam ? (idx == 5'd3) : (idx == 5'd0);
  assign gbase     = {idx[1:0], 2'b00};

  assign t_exp = (tcnt == TLAST) & ~srt_done;

  assign err_set =
    ((state == IDLE) & s_valid & mode_in[1]) |
    ((state == WAIT) & t_exp);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (xfer) nxt = COLLECT;
      end
      COLLECT: begin
        if (xfer && col_last) nxt = START;
      end
      START: begin
        nxt = FEED;
      end
      FEED: begin
        if (feed_last) nxt = WAIT;
      end
      WAIT: begin
        if (srt_done) nxt = OUT;
        else if (t_exp) nxt = IDLE;
      end
      OUT: begin
        if (m_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs; everything is forced low while reset is held
  always_comb begin
    s_ready   = 1'b0;
    srt_start = 1'b0;
    srt_M     = 2'b00;
    srt_d1    = '0;
    srt_d2    = '0;
    srt_d3    = '0;
    srt_d4    = '0;
    m_valid   = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          s_ready = ~mode_in[1];
        end
        COLLECT: begin
          s_ready = 1'b1;
        end
        START: begin
          srt_start = 1'b1;
          srt_M     = mode_q;
        end
        FEED: begin
          srt_M  = mode_q;
          srt_d1 = sbuf[gbase];
          srt_d2 = sbuf[gbase + 4'd1];
          srt_d3 = sbuf[gbase + 4'd2];
          srt_d4 = sbuf[gbase + 4'd3];
        end
        WAIT: begin
          srt_M = mode_q;
        end
        OUT: begin
          srt_M   = mode_q;
          m_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sample buffer; stale contents are harmless since the
  // index restarts at zero for every frame.
  always_ff @(posedge clk) begin
    if (xfer) begin
      sbuf[idx[3:0]] <= s_data;
    end
  end

  // Counters, mode latch, result register, error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      tcnt   <= '0;
      mode_q <= 2'b00;
      m_data <= '0;
      err    <= 1'b0;
    end else begin
      err <= err_set;
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (xfer) begin
            mode_q <= mode_in;
            idx    <= 5'd1;
          end
        end
        COLLECT: begin
          if (xfer) begin
            idx <= col_last ? 5'd0 : idx + 5'd1;
          end
        end
        START: begin
          idx <= 5'd0;
        end
        FEED: begin
          idx  <= feed_last ? 5'd0 : idx + 5'd1;
          tcnt <= '0;
        end
        WAIT: begin
          idx <= 5'd0;
          if (srt_done) begin
            m_data <= srt_y;
            tcnt   <= '0;
          end else if (t_exp) begin
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        OUT: begin
          tcnt <= '0;
          if (m_ready) idx <= 5'd0;
        end
        default: begin
          idx  <= 5'd0;
          tcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_ctrl.sv
// tb_sorter_ctrl: randomized self-checking bench for sorter_ctrl,
// comparing against a frame-level reference of the expected behaviour.
module tb_sorter_ctrl;

  localparam int W  = 8;
  localparam int NO = 4;
  localparam int TO = 64;
  localparam int OW = NO * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode_in;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          srt_start;
  logic [1:0]    srt_M;
  logic [W-1:0]  srt_d1;
  logic [W-1:0]  srt_d2;
  logic [W-1:0]  srt_d3;
  logic [W-1:0]  srt_d4;
  logic          srt_done;
  logic [OW-1:0] srt_y;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          busy;
  logic          err;

  int vec = 0;
  int bad = 0;

  logic [W-1:0] qpsk_v [4];

  always #5 clk = ~clk;

  sorter_ctrl #(
    .WIDTH(W),
    .NUM_OUTPUTS(NO),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode_in(mode_in),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .srt_start(srt_start),
    .srt_M(srt_M),
    .srt_d1(srt_d1),
    .srt_d2(srt_d2),
    .srt_d3(srt_d3),
    .srt_d4(srt_d4),
    .srt_done(srt_done),
    .srt_y(srt_y),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .busy(busy),
    .err(err)
  );

  task automatic test_reset();
    rst = 1'b1;
    mode_in = 2'b00;
    s_valid = 1'b1;
    s_data = 8'h55;
    srt_done = 1'b0;
    srt_y = '0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if ({s_ready, srt_start, srt_M, m_valid, busy, err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0",
        {s_ready, srt_start, srt_M, m_valid, busy, err});
    end
    vec++;
    if ({srt_d1, srt_d2, srt_d3, srt_d4, m_data} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h %h want 0",
        {srt_d1, srt_d2, srt_d3, srt_d4}, m_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: ready=%b busy=%b want 1 0",
        s_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  // One complete frame: collect (with random gaps), start, feed,
  // wait ddly cycles for the sorter, hold result rdly cycles.
  task automatic test_frame(input logic [1:0] md, input bit directed,
                            input int rdly, input int ddly);
    int n;
    int i;
    logic [W-1:0]    smp [16];
    logic [OW-1:0]   y;
    logic [4*W-1:0]  grp;
    n = (md == 2'b01) ? 16 : 4;
    for (int k = 0; k < n; k++) begin
      if (directed) smp[k] = (md == 2'b01) ? W'(k) : qpsk_v[k];
      else smp[k] = W'($urandom);
    end
    y = OW'($urandom);
    i = 0;
    while (i < n) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        mode_in = 2'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = smp[i];
        mode_in = (i == 0) ? md : 2'($urandom);
      end
      srt_done = 1'($urandom);
      srt_y = OW'($urandom);
      @(negedge clk);
      vec++;
      if (s_ready !== 1'b1) begin
        bad++;
        $display("FAIL collect_ready: i=%0d got %b want 1", i, s_ready);
      end
      vec++;
      if (srt_start !== 1'b0 || {srt_d1, srt_d2, srt_d3, srt_d4} !== '0) begin
        bad++;
        $display("FAIL collect_quiet: start=%b d=%h want 0 0", srt_start,
          {srt_d1, srt_d2, srt_d3, srt_d4});
      end
      @(posedge clk); #1;
      if (s_valid) i++;
    end
    s_valid = 1'b1;
    s_data = W'($urandom);
    mode_in = 2'($urandom);
    @(negedge clk);
    vec++;
    if ({srt_start, srt_M, s_ready, busy} !== {1'b1, md, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL start: got start=%b M=%b rdy=%b busy=%b want 1 %b 0 1",
        srt_start, srt_M, s_ready, busy, md);
    end
    vec++;
    if ({srt_d1, srt_d2, srt_d3, srt_d4} !== '0) begin
      bad++;
      $display("FAIL start_data: got %h want 0",
        {srt_d1, srt_d2, srt_d3, srt_d4});
    end
    @(posedge clk); #1;
    for (int g = 0; g < n / 4; g++) begin
      s_valid = 1'($urandom);
      srt_done = 1'($urandom);
      srt_y = OW'($urandom);
      grp = {smp[4*g], smp[4*g+1], smp[4*g+2], smp[4*g+3]};
      @(negedge clk);
      vec++;
      if ({srt_d1, srt_d2, srt_d3, srt_d4} !== grp) begin
        bad++;
        $display("FAIL feed_g%0d: got %h want %h", g,
          {srt_d1, srt_d2, srt_d3, srt_d4}, grp);
      end
      vec++;
      if ({srt_start, srt_M, s_ready} !== {1'b0, md, 1'b0}) begin
        bad++;
        $display("FAIL feed_ctl: got start=%b M=%b rdy=%b want 0 %b 0",
          srt_start, srt_M, s_ready, md);
      end
      @(posedge clk); #1;
    end
    srt_done = 1'b0;
    for (int k = 0; k < ddly; k++) begin
      s_valid = 1'($urandom);
      @(negedge clk);
      vec++;
      if ({m_valid, busy, srt_M, s_ready} !== {1'b0, 1'b1, md, 1'b0} ||
          {srt_d1, srt_d2, srt_d3, srt_d4} !== '0) begin
        bad++;
        $display("FAIL wait: got mv=%b busy=%b M=%b rdy=%b d=%h want 0 1 %b 0 0",
          m_valid, busy, srt_M, s_ready,
          {srt_d1, srt_d2, srt_d3, srt_d4}, md);
      end
      @(posedge clk); #1;
    end
    srt_done = 1'b1;
    srt_y = y;
    @(negedge clk);
    vec++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle_valid: got %b want 0", m_valid);
    end
    @(posedge clk); #1;
    srt_done = 1'b0;
    srt_y = OW'($urandom);
    for (int k = 0; k <= rdly; k++) begin
      m_ready = (k == rdly);
      s_valid = 1'($urandom);
      @(negedge clk);
      vec++;
      if ({m_valid, s_ready, busy} !== 3'b101 || m_data !== y) begin
        bad++;
        $display("FAIL out: got mv=%b rdy=%b busy=%b data=%h want 1 0 1 %h",
          m_valid, s_ready, busy, m_data, y);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    mode_in = 2'b00;
    @(negedge clk);
    vec++;
    if ({m_valid, busy, srt_M} !== 4'b0) begin
      bad++;
      $display("FAIL back_idle: got mv=%b busy=%b M=%b want 0 0 00",
        m_valid, busy, srt_M);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved();
    for (int r = 0; r < 4; r++) begin
      s_valid = 1'b1;
      mode_in = 2'($urandom_range(2, 3));
      s_data = W'($urandom);
      @(negedge clk);
      vec++;
      if ({s_ready, busy} !== 2'b00) begin
        bad++;
        $display("FAIL reserved_rdy: got rdy=%b busy=%b want 0 0",
          s_ready, busy);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      mode_in = 2'b00;
      @(negedge clk);
      vec++;
      if ({err, busy} !== 2'b10) begin
        bad++;
        $display("FAIL reserved_err: got err=%b busy=%b want 1 0", err, busy);
      end
      @(posedge clk); #1;
      @(negedge clk);
      vec++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL reserved_pulse: got err=%b want 0", err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int first;
    int errs;
    bit mv;
    first = -1;
    errs = 0;
    mv = 1'b0;
    srt_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      mode_in = 2'b00;
      s_data = W'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    for (int k = 1; k <= TO + 10; k++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        errs++;
        if (first < 0) first = k;
      end
      if (m_valid !== 1'b0) mv = 1'b1;
      @(posedge clk); #1;
    end
    vec++;
    if (first != TO + 3) begin
      bad++;
      $display("FAIL timeout_cycle: got %0d want %0d", first, TO + 3);
    end
    vec++;
    if (errs != 1) begin
      bad++;
      $display("FAIL timeout_pulse: got %0d cycles want 1", errs);
    end
    vec++;
    if (mv) begin
      bad++;
      $display("FAIL timeout_mvalid: got 1 want 0");
    end
    vec++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1;
      mode_in = 2'b01;
      s_data = W'(k);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({s_ready, busy, srt_M, srt_start, m_valid} !== 6'b0) begin
      bad++;
      $display("FAIL abort_rst: got %b want 0",
        {s_ready, busy, srt_M, srt_start, m_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (srt_start !== 1'b0 || busy !== 1'b0 || m_data !== '0) seen = 1'b1;
      @(posedge clk); #1;
    end
    vec++;
    if (seen) begin
      bad++;
      $display("FAIL abort_quiet: got activity want none");
    end
    test_frame(2'b00, 1'b1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 20; f++) begin
      test_frame(2'($urandom_range(0, 1)), 1'b0,
                 $urandom_range(0, 5), $urandom_range(0, 8));
    end
  endtask

  initial begin
    qpsk_v[0] = 8'd10;
    qpsk_v[1] = 8'd20;
    qpsk_v[2] = 8'd1;
    qpsk_v[3] = 8'd0;
    test_reset();
    test_frame(2'b00, 1'b1, 0, 0);
    test_frame(2'b01, 1'b1, 2, 3);
    test_reserved();
    test_timeout();
    test_reset_abort();
    test_frame(2'b00, 1'b1, 10, 1);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
